multi_channel_averager: RTL

- Parametrised N-channel signed averager for the accelerometer path. It supersedes the fixed four-instance X/Y/Z/T averaging wrapper.
- Takes one packed sample vector per strobe and averages every channel over a 2^LOG2_DEPTH window. It runs in either block (decimating) or sliding (moving-average) mode.
- Sits between the raw-to-binary converter and the display/UART formatter. Adds clear/flush, mode switching and fill reporting.

---
 rtl/multi_channel_averager.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multi_channel_averager.sv
// multi_channel_averager: NUM_CH signed channels averaged over a 2^LOG2_DEPTH window,
// block (decimating) or sliding (moving average), with a three-stage pipeline.
module multi_channel_averager #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 19,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_mode,
  input  logic                         i_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_avg,
  output logic                         o_valid,
  output logic [LOG2_DEPTH:0]          o_fill
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = DATA_WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL     = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   FILL_ONE = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] WP_ONE   = LOG2_DEPTH'(1);

  typedef logic signed [ACC_W-1:0]      acc_t;
  typedef logic signed [DATA_WIDTH-1:0] smp_t;

  logic                         mode;
  logic                         flush;
  logic                         take;
  logic                         at_full;
  logic                         s0_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] s0_data;
  acc_t                         sum      [NUM_CH];
  acc_t                         sum_next [NUM_CH];
  acc_t                         fresh    [NUM_CH];
  acc_t                         oldest   [NUM_CH];
  smp_t                         avg_next [NUM_CH];
  smp_t                         buf_mem  [NUM_CH][DEPTH];
  logic [DEPTH-1:0]             occupied;
  logic [LOG2_DEPTH-1:0]        wp;
  logic [LOG2_DEPTH:0]          fill;
  logic [LOG2_DEPTH:0]          fill_next;
  logic                         fire;

  // A mode change behaves exactly like a clear on the same edge.
  always_comb begin
    flush   = i_clear | (i_mode != mode);
    take    = s0_valid & ~flush;
    at_full = (fill == FULL);
    if (mode) fill_next = at_full ? FULL : fill + FILL_ONE;
    else      fill_next = (at_full ? {(LOG2_DEPTH+1){1'b0}} : fill) + FILL_ONE;
  end

  // Unoccupied buffer slots read as zero, so the sliding subtraction is exact while filling.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      fresh[k]  = acc_t'(smp_t'(s0_data[k*DATA_WIDTH +: DATA_WIDTH]));
      oldest[k] = occupied[wp] ? acc_t'(buf_mem[k][wp]) : {ACC_W{1'b0}};
      if (mode)         sum_next[k] = sum[k] + fresh[k] - oldest[k];
      else if (at_full) sum_next[k] = fresh[k];
      else              sum_next[k] = sum[k] + fresh[k];
      avg_next[k] = smp_t'(sum[k] >>> LOG2_DEPTH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode     <= 1'b0;
      s0_valid <= 1'b0;
      s0_data  <= '0;
      fill     <= '0;
      wp       <= '0;
      occupied <= '0;
      fire     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        sum[k] <= '0;
        for (int d = 0; d < DEPTH; d++) buf_mem[k][d] <= '0;
      end
    end else begin
      mode     <= i_mode;
      s0_valid <= i_valid & ~flush;
      s0_data  <= i_data;
      fire     <= take && (fill_next == FULL);
      if (flush) begin
        for (int k = 0; k < NUM_CH; k++) sum[k] <= '0;
        fill     <= '0;
        wp       <= '0;
        occupied <= '0;
      end else if (take) begin
        for (int k = 0; k < NUM_CH; k++) sum[k] <= sum_next[k];
        fill <= fill_next;
        if (mode) begin
          for (int k = 0; k < NUM_CH; k++)
            buf_mem[k][wp] <= smp_t'(s0_data[k*DATA_WIDTH +: DATA_WIDTH]);
          occupied[wp] <= 1'b1;
          wp           <= wp + WP_ONE;
        end
      end else if (!mode && at_full) begin
        // A completed block with no follow-on sample restarts the window here.
        for (int k = 0; k < NUM_CH; k++) sum[k] <= '0;
        fill <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_avg   <= '0;
    end else begin
      o_valid <= fire & ~flush;
      if (fire & ~flush) begin
        for (int k = 0; k < NUM_CH; k++)
          o_avg[k*DATA_WIDTH +: DATA_WIDTH] <= avg_next[k];
      end
    end
  end

  assign o_fill = fill;

endmodule
